// File: rtl/dualport_ram.sv
// Simple dual-port RAM (one write port, one read port, one clock) with byte enables,
// a 1- or 2-cycle registered read path, selectable read-during-write policy and a post-reset zero-fill.
module dualport_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    init_busy,
  output logic                    req_drop
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("dualport_ram: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("dualport_ram: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mergedWord;
  logic [DATA_WIDTH-1:0]   rdWord;
  logic                    rdFire;
  logic                    s1Valid_q;
  logic [DATA_WIDTH-1:0]   s1Data_q;
  logic                    reqDrop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign rdFire    = rd_en && !init_busy;

  // The array itself has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_busy) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            mem_q[wr_addr][8*i +: 8] <= data_in[8*i +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    mergedWord = mem_q[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        mergedWord[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // Write-first bypass: a same-address read sees the word as it will be after this edge.
  always_comb begin
    rdWord = mem_q[rd_addr];
    if ((RDW_MODE == 1) && wr_en && (wr_addr == rd_addr)) begin
      rdWord = mergedWord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      reqDrop_q <= 1'b0;
    end else begin
      s1Valid_q <= rdFire;
      if (rdFire) begin
        s1Data_q <= rdWord;
      end
      reqDrop_q <= init_busy && (wr_en || rd_en);
    end
  end

  assign req_drop = reqDrop_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2Valid_q;
    logic [DATA_WIDTH-1:0] s2Data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2Valid_q <= 1'b0;
        s2Data_q  <= '0;
      end else begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Data_q <= s1Data_q;
        end
      end
    end

    assign rd_valid = s2Valid_q;
    assign data_out = s2Data_q;
  end else begin : g_lat1
    assign rd_valid = s1Valid_q;
    assign data_out = s1Data_q;
  end

endmodule

// File: tb/tb_dualport_ram.sv
// Scoreboard bench for dualport_ram: three instances (read-first/lat1, write-first/lat1,
// read-first/lat2) share one stimulus stream; a reference memory predicts every read result.
module tb_dualport_ram;

  localparam int DW = 128;
  localparam int AW = 3;
  localparam int NB = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } expEntry_t;
  typedef expEntry_t entryQ_t[$];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] dOutA, dOutB, dOutC;
  logic          vA, vB, vC;
  logic          busyA, busyB, busyC;
  logic          dropA, dropB, dropC;

  entryQ_t       qA, qB, qC;
  logic [DW-1:0] lastD [3];
  logic [DW-1:0] modelMem [8];
  bit            modelBusy;
  int            cycleCount = 0;
  int            assertCount = 0;
  int            failCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  dualport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0)) dutA (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dOutA),
    .rd_valid(vA), .init_busy(busyA), .req_drop(dropA));

  dualport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(1)) dutB (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dOutB),
    .rd_valid(vB), .init_busy(busyB), .req_drop(dropB));

  dualport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(0)) dutC (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dOutC),
    .rd_valid(vC), .init_busy(busyC), .req_drop(dropC));

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitorOne(input string name, input logic v, input logic [DW-1:0] d,
                            inout entryQ_t q, inout logic [DW-1:0] lastData);
    expEntry_t e;
    if (v) begin
      if (q.size() == 0) begin
        checkOutput({name, ".spurious_valid"}, DW'(v), DW'(0));
      end else begin
        e = q.pop_front();
        checkOutput({name, ".data"}, d, e.data);
        checkOutput({name, ".latency"}, DW'(cycleCount), DW'(e.due));
        lastData = e.data;
      end
    end else begin
      if ((q.size() != 0) && (q[0].due <= cycleCount)) begin
        checkOutput({name, ".missing_valid"}, DW'(v), DW'(1));
        void'(q.pop_front());
      end
      checkOutput({name, ".hold"}, d, lastData);
    end
  endtask

  always @(negedge clk) begin
    monitorOne("A", vA, dOutA, qA, lastD[0]);
    monitorOne("B", vB, dOutB, qB, lastD[1]);
    monitorOne("C", vC, dOutC, qC, lastD[2]);
  end

  // Drives one cycle of requests and predicts every read result at the same moment.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                               input logic [DW-1:0] din, input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] oldWord;
    logic [DW-1:0] mergedWord;
    expEntry_t     e;
    @(negedge clk);
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    data_in = din;
    rd_en   = re;
    rd_addr = ra;
    if (!modelBusy) begin
      oldWord    = modelMem[ra];
      mergedWord = modelMem[wa];
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mergedWord[8*i +: 8] = din[8*i +: 8];
      end
      if (re) begin
        e.data = oldWord;
        e.due  = cycleCount + 1;
        qA.push_back(e);
        e.due  = cycleCount + 2;
        qC.push_back(e);
        e.data = (we && (wa == ra)) ? mergedWord : oldWord;
        e.due  = cycleCount + 1;
        qB.push_back(e);
      end
      if (we) modelMem[wa] = mergedWord;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic assertReset();
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rst_n     = 1'b0;
    modelBusy = 1'b1;
    qA.delete();
    qB.delete();
    qC.delete();
    for (int i = 0; i < 3; i++) lastD[i] = '0;
    for (int i = 0; i < 8; i++) modelMem[i] = '0;
    #1;
    checkOutput("reset.rd_valid_A", DW'(vA), DW'(0));
    checkOutput("reset.rd_valid_B", DW'(vB), DW'(0));
    checkOutput("reset.rd_valid_C", DW'(vC), DW'(0));
    checkOutput("reset.data_out_A", dOutA, '0);
    checkOutput("reset.data_out_B", dOutB, '0);
    checkOutput("reset.data_out_C", dOutC, '0);
    checkOutput("reset.init_busy", DW'(busyA), DW'(1));
    checkOutput("reset.init_busy_C", DW'(busyC), DW'(1));
    checkOutput("reset.req_drop", DW'(dropA), DW'(0));
  endtask

  task automatic releaseAndSweep(input bit dropPulse);
    @(negedge clk);
    rst_n = 1'b1;
    if (dropPulse) begin
      wr_en   = 1'b1;
      wr_addr = 3'd1;
      wr_be   = '1;
      data_in = 128'h55;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("init.busy", DW'(busyA), DW'(k < 8));
      checkOutput("init.req_drop", DW'(dropA), DW'(dropPulse && (k == 1)));
      wr_en = 1'b0;
    end
    modelBusy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; data_in = '0;
    rd_en = 1'b0; rd_addr = '0; modelBusy = 1'b1;
    #1;
    assertReset();
    releaseAndSweep(1'b0);

    // Fill with nonzero data, then reset and expect the sweep to have zeroed everything.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, AW'(i), '1, {16{8'(i + 1)}}, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd4);
    idle(2);
    @(posedge clk);
    #2;
    assertReset();
    releaseAndSweep(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(i));

    applyStimulus(1'b1, 3'd5, '1, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd5);
    applyStimulus(1'b1, 3'd2, 16'h8001, '1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd2);

    applyStimulus(1'b1, 3'd3, '1, 128'h11, 1'b0, '0);
    applyStimulus(1'b1, 3'd3, '1, 128'h22, 1'b1, 3'd3);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd3);
    applyStimulus(1'b1, 3'd3, 16'h0003, 128'hABCD_EF01, 1'b1, 3'd3);
    applyStimulus(1'b1, 3'd6, '1, 128'h66, 1'b1, 3'd5);
    applyStimulus(1'b1, 3'd5, 16'h0000, '1, 1'b1, 3'd5);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd6);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, AW'(i), '1, DW'(i), 1'b0, '0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(i));
    idle(3);

    // Reset lands while reads are still in flight; nothing from that burst may surface.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(i + 4));
    @(posedge clk);
    #2;
    checkOutput("burst.valid_A", DW'(vA), DW'(1));
    checkOutput("burst.valid_C", DW'(vC), DW'(1));
    assertReset();
    releaseAndSweep(1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 3'd7);
    idle(4);

    checkOutput("drain.A", DW'(qA.size()), DW'(0));
    checkOutput("drain.B", DW'(qB.size()), DW'(0));
    checkOutput("drain.C", DW'(qC.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
